spm_way_cfg_ctrl: RTL and testbench
===================================

// Module: spm_way_cfg_ctrl
// PURPOSE
//  Sequences the switch of I-cache ways between cache mode and SPM mode.
//  On a config write it stalls all users of the way memories and waits for them to go idle.
//  It then zeroes every line (data + tag) of each way whose mode changes, and only then
//  publishes the new active-way mask to the SPM controller and the cache.
//  Sits between the CSR file and the way SRAMs. Owns the SRAM port only while sweeping.
// PARAMETERS
//  NR_WAYS       4     number of cache ways
//  NR_LINES      256   lines per way; power of two, >= 2
//  MEMORY_WIDTH  173   SRAM word width (line + tag)
//  RESET_WAYS    '0    active_ways_o value after reset (all ways in cache mode)
//  LINE_IDX_W = $clog2(NR_LINES) (localparam)
// PORTS
//  clk_i            in   1                     clock
//  rst_ni           in   1                     asynchronous reset, active low
//  cfg_we_i         in   1                     CSR write strobe, one cycle
//  cfg_ways_i       in   NR_WAYS               requested SPM-way mask
//  cfg_busy_o       out  1                     reconfiguration in progress
//  active_ways_o    out  NR_WAYS               committed SPM-way mask
//  stall_req_o      out  1                     stall fetch + LSU SPM/cache accesses
//  users_idle_i     in   1                     all way-memory users quiescent
//  mem_req_o        out  NR_WAYS               per-way SRAM request
//  mem_addr_o       out  LINE_IDX_W            line index, shared by all ways
//  mem_we_o         out  1                     write enable (1 whenever mem_req_o != 0)
//  mem_be_o         out  (MEMORY_WIDTH+7)/8    byte enables, all ones while sweeping
//  mem_wdata_o      out  MEMORY_WIDTH          always zero
//  mem_gnt_i        in   1                     sweep write accepted this cycle
// BEHAVIOUR
//  Reset values:
//   - active_ways_o=RESET_WAYS; all other outputs 0.
//   - Internal registers: state=IDLE, pending='0, counter='0.
//  FSM IDLE -> DRAIN -> CLEAR -> COMMIT -> IDLE (all registered):
//   - IDLE: cfg_we_i && cfg_ways_i!=active_ways_o => pending<=cfg_ways_i,
//     changed<=cfg_ways_i^active_ways_o, go to DRAIN.
//   - IDLE: cfg_we_i with an equal mask is a no-op; busy stays 0.
//   - DRAIN: stall_req_o=1, cfg_busy_o=1. The cycle users_idle_i=1 is seen => CLEAR, counter<=0.
//   - CLEAR: mem_req_o=changed, mem_addr_o=counter, mem_we_o=1, mem_be_o='1, mem_wdata_o=0.
//     Counter advances only when mem_gnt_i=1; without gnt, addr and req are held stable.
//     mem_gnt_i=1 with counter==NR_LINES-1 => COMMIT; counter wraps to 0.
//   - COMMIT: active_ways_o<=pending, go to IDLE. stall_req_o and cfg_busy_o are 0 from IDLE on.
//   - stall_req_o=1 and cfg_busy_o=1 throughout DRAIN, CLEAR and COMMIT.
//  Latency, cfg_we_i to new mask visible, with users idle and gnt always high:
//   - NR_LINES+3 cycles: 1 IDLE, 1 DRAIN, NR_LINES CLEAR, 1 COMMIT.
//  Unchanged ways:
//   - never requested during the sweep; their contents are preserved.
//  cfg_we_i while cfg_busy_o=1: ignored entirely; pending is not altered.
//   - Software must poll cfg_busy_o and rewrite.
//  active_ways_o changes only in COMMIT: never mid-sweep, never glitching.
//  users_idle_i dropping during CLEAR: no effect (stall_req_o already holds users off).
//  Reset asserted mid-sweep:
//   - Returns to the reset values immediately; the partial sweep is abandoned.
//   - active_ways_o=RESET_WAYS.
//  Switching SPM->cache zeroes tags (invalidates lines). Switching cache->SPM zeroes data
//  (no stale cache contents leak into SPM).
// TESTING
//  1. Reset, then cfg_we_i with ways=4'b0011, idle=1, gnt=1 => req=4'b0011 at addr 0..255.
//     active_ways_o=4'b0011 exactly 259 cycles after the write.
//  2. Active=4'b0011, write 4'b0110 => only ways 0 and 2 swept.
//     Ways 1 and 3 see no req; final mask 4'b0110.
//  3. users_idle_i held 0 for 10 cycles => stall_req_o=1, no mem_req_o.
//     Sweep starts the cycle after idle=1.
//  4. gnt toggled randomly => every address 0..NR_LINES-1 written exactly once, in order.
//     addr held while gnt=0.
//  5. Second cfg_we_i (ways=4'b1111) during CLEAR => ignored; commits the first mask.
//     Equal-mask write in IDLE => busy never rises.
//  6. rst_ni low at counter=100 => all outputs reset asynchronously.
//     active_ways_o=RESET_WAYS; a fresh write completes normally.

Source files
------------

// File: rtl/spm_way_cfg_ctrl.sv
// Switches I-cache ways between cache and SPM mode: stall users, wait for idle, zero changed ways, then commit the mask.
// Write-to-commit takes NR_LINES+3 cycles with idle users and constant grant; the sweep pauses while mem_gnt_i is low.
module spm_way_cfg_ctrl #(
  parameter int                  NR_WAYS      = 4,
  parameter int                  NR_LINES     = 256,
  parameter int                  MEMORY_WIDTH = 173,
  parameter logic [NR_WAYS-1:0]  RESET_WAYS   = '0,
  localparam int                 LINE_IDX_W   = $clog2(NR_LINES),
  localparam int                 BE_W         = (MEMORY_WIDTH + 7) / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_we_i,
  input  logic [NR_WAYS-1:0]      cfg_ways_i,
  output logic                    cfg_busy_o,
  output logic [NR_WAYS-1:0]      active_ways_o,
  output logic                    stall_req_o,
  input  logic                    users_idle_i,
  output logic [NR_WAYS-1:0]      mem_req_o,
  output logic [LINE_IDX_W-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [BE_W-1:0]         mem_be_o,
  output logic [MEMORY_WIDTH-1:0] mem_wdata_o,
  input  logic                    mem_gnt_i
);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, COMMIT} state_t;

  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(NR_LINES - 1);

  state_t                  state;
  logic [NR_WAYS-1:0]      pending;
  logic [NR_WAYS-1:0]      changed;
  logic [LINE_IDX_W-1:0]   counter;
  logic                    sweep;

  assign mem_addr_o  = counter;
  assign mem_we_o    = sweep;
  assign mem_be_o    = {BE_W{sweep}};
  assign mem_wdata_o = '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      pending       <= '0;
      changed       <= '0;
      counter       <= '0;
      sweep         <= 1'b0;
      mem_req_o     <= '0;
      stall_req_o   <= 1'b0;
      cfg_busy_o    <= 1'b0;
      active_ways_o <= RESET_WAYS;
    end else begin
      case (state)
        IDLE: begin
          // Writes of the current mask leave the ways untouched and never raise busy.
          if (cfg_we_i && (cfg_ways_i != active_ways_o)) begin
            pending     <= cfg_ways_i;
            changed     <= cfg_ways_i ^ active_ways_o;
            stall_req_o <= 1'b1;
            cfg_busy_o  <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (users_idle_i) begin
            counter   <= '0;
            mem_req_o <= changed;
            sweep     <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          // Address and request stay put until the SRAM accepts the write.
          if (mem_gnt_i) begin
            counter <= counter + LINE_IDX_W'(1);
            if (counter == LAST_LINE) begin
              mem_req_o <= '0;
              sweep     <= 1'b0;
              state     <= COMMIT;
            end
          end
        end
        COMMIT: begin
          active_ways_o <= pending;
          stall_req_o   <= 1'b0;
          cfg_busy_o    <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_way_cfg_ctrl.sv
// Randomized bench for spm_way_cfg_ctrl; a transaction-level model tracks the committed mask and the expected sweep.
module tb_spm_way_cfg_ctrl;
  localparam int NW = 4;
  localparam int NL = 256;
  localparam int MW = 173;
  localparam int BW = (MW + 7) / 8;
  localparam int AW = $clog2(NL);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cfg_we_i;
  logic [NW-1:0] cfg_ways_i;
  logic          cfg_busy_o;
  logic [NW-1:0] active_ways_o;
  logic          stall_req_o;
  logic          users_idle_i;
  logic [NW-1:0] mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [MW-1:0] mem_wdata_o;
  logic          mem_gnt_i;

  spm_way_cfg_ctrl #(
    .NR_WAYS(NW), .NR_LINES(NL), .MEMORY_WIDTH(MW), .RESET_WAYS('0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_ways_i(cfg_ways_i), .cfg_busy_o(cfg_busy_o),
    .active_ways_o(active_ways_o), .stall_req_o(stall_req_o), .users_idle_i(users_idle_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i)
  );

  always #5 clk_i = ~clk_i;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [NW-1:0] model_active;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},   cfg_busy_o,    1'b0);
    check({pfx, "_stall"},  stall_req_o,   1'b0);
    check({pfx, "_req"},    mem_req_o,     '0);
    check({pfx, "_we"},     mem_we_o,      1'b0);
    check({pfx, "_be"},     mem_be_o,      '0);
    check({pfx, "_wdata"},  mem_wdata_o,   '0);
    check({pfx, "_active"}, active_ways_o, model_active);
  endtask

  // One config write; extra_addr injects a second write mid-sweep, rst_addr pulls reset mid-sweep.
  task automatic sweep(input logic [NW-1:0] ways, input int idle_delay, input bit rnd_gnt,
                       input int extra_addr, input int rst_addr);
    logic [NW-1:0] chg;
    int cyc, exp_addr, first_req, exp_first;
    int bad_stall, bad_req, bad_addr, bad_data, stray;
    bit done, g;
    chg = ways ^ model_active;
    cyc = 0; exp_addr = 0; first_req = -1; done = 1'b0;
    bad_stall = 0; bad_req = 0; bad_addr = 0; bad_data = 0; stray = 0;
    exp_first = (idle_delay == 0) ? 2 : idle_delay + 2;
    cfg_ways_i   = ways;
    cfg_we_i     = 1'b1;
    users_idle_i = (idle_delay == 0);
    mem_gnt_i    = 1'b1;
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
    cyc = 1;
    if (chg == '0) begin
      repeat (4) begin
        check("noop", {cfg_busy_o, stall_req_o, active_ways_o}, {2'b00, model_active});
        @(posedge clk_i); #1;
      end
      return;
    end
    while (!done && cyc < 2000) begin
      if (active_ways_o !== model_active) begin
        done = 1'b1;
      end else begin
        if (stall_req_o !== 1'b1 || cfg_busy_o !== 1'b1) bad_stall++;
        if (mem_req_o != '0) begin
          if (first_req < 0) first_req = cyc;
          if (mem_req_o !== chg) bad_req++;
          if ((mem_req_o & ~chg) != '0) stray++;
          if (exp_addr >= NL || mem_addr_o !== exp_addr[AW-1:0]) bad_addr++;
          if (mem_we_o !== 1'b1 || mem_be_o !== {BW{1'b1}} || mem_wdata_o !== '0) bad_data++;
        end else if (mem_we_o !== 1'b0) begin
          bad_data++;
        end
        if (rst_addr >= 0 && mem_req_o != '0 && exp_addr == rst_addr) begin
          check("rst_at_addr", mem_addr_o, rst_addr);
          #2 rst_ni = 1'b0;
          #1;
          model_active = '0;
          check_quiet("async_rst");
          check("async_rst_addr", mem_addr_o, '0);
          cfg_we_i = 1'b0;
          repeat (2) @(posedge clk_i);
          #1 rst_ni = 1'b1;
          check_quiet("post_rst");
          return;
        end
        cfg_we_i = 1'b0;
        if (extra_addr >= 0 && mem_req_o != '0 && exp_addr == extra_addr) begin
          cfg_we_i   = 1'b1;
          cfg_ways_i = '1;
        end
        g = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_gnt_i = g;
        if (mem_req_o != '0 && g) exp_addr++;
        if (idle_delay > 0 && cyc == idle_delay + 1) users_idle_i = 1'b1;
        if (rnd_gnt && first_req >= 0) users_idle_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    cfg_we_i = 1'b0;
    check("sweep_done", done, 1'b1);
    check("new_mask", active_ways_o, ways);
    check("lines_written", exp_addr, NL);
    check("first_req_cycle", first_req, exp_first);
    check("stall_busy_held", bad_stall, 0);
    check("req_mask", bad_req, 0);
    check("unchanged_ways_req", stray, 0);
    check("addr_order", bad_addr, 0);
    check("write_fields", bad_data, 0);
    if (!rnd_gnt && idle_delay == 0) check("latency", cyc, NL + 3);
    model_active = ways;
    repeat (3) begin
      check_quiet("after_commit");
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    logic [NW-1:0] r;
    rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_ways_i = '0; users_idle_i = 1'b0; mem_gnt_i = 1'b0;
    model_active = '0;
    #1;
    check_quiet("reset");
    check("reset_addr", mem_addr_o, '0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    check_quiet("reset_release");

    sweep(4'b0011, 0, 1'b0, -1, -1);
    sweep(4'b0110, 0, 1'b0, -1, -1);
    sweep(4'b1100, 10, 1'b0, -1, -1);
    sweep(4'b0101, 0, 1'b1, -1, -1);
    sweep(4'b1000, 0, 1'b0, 50, -1);
    sweep(4'b1000, 0, 1'b0, -1, -1);
    sweep(4'b0111, 0, 1'b0, -1, 100);
    sweep(4'b0011, 0, 1'b0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      r = NW'($urandom);
      sweep(r, $urandom_range(0, 5), 1'b1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
